game_progress: RTL and testbench

GAME_PROGRESS -- requirements
Module: game_progress

---
 rtl/game_pkg.sv | 24 ++
 rtl/blink_timer.sv | 39 +++
 rtl/game_progress.sv | 134 +++++++++++++
 tb/tb_game_progress.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// +--------------------------------------------------------------------+
// | game_pkg : shared FSM state enum and 7-segment digit-code constants |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } state_t;

   // Codes 0..15 render as hex; the two extra glyphs sit outside that range.
   typedef logic [4:0] digit_t;

   localparam digit_t SEG_DASH = 5'd16;
   localparam digit_t SEG_OFF  = 5'd31;

endpackage

`default_nettype wire

// File: rtl/blink_timer.sv
// +--------------------------------------------------------------------+
// | blink_timer : free-running half-period divider producing a blink   |
// |               phase; held at its reset values while restart is high|
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module blink_timer #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic phase
);

   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             phase_q;

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (cnt_q == CNT_MAX) begin
         cnt_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt_q   <= cnt_q + 1'b1;
      end
   end

   assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/game_progress.sv
// +--------------------------------------------------------------------+
// | game_progress : score/lives game FSM with registered 7-segment     |
// |                 digit codes and blinking WIN/LOSE indication       |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module game_progress
   import game_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int WIN_COUNT = 7,
   parameter int LIVES     = 3,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  hit,
   input  logic                  miss,
   output logic [5*N_DIGITS-1:0] bits,
   output logic                  victoryflag,
   output logic                  loseflag
);

   localparam logic [3:0] WIN_C   = 4'(WIN_COUNT);
   localparam logic [3:0] LIVES_C = 4'(LIVES);

   state_t state_q, state_d;
   logic [3:0] score_q, score_d;
   logic [3:0] lives_q, lives_d;
   logic [5*N_DIGITS-1:0] bits_q, disp_d;
   logic victory_q, lose_q;
   logic restart;
   logic phase;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         score_q <= '0;
         lives_q <= LIVES_C;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         lives_q <= lives_d;
      end
   end

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      lives_d = lives_q;
      case (state_q)
         ST_PLAY: begin
            if (start) begin
               score_d = '0;
               lives_d = LIVES_C;
            end else if (hit) begin
               score_d = score_q + 4'd1;
               if (score_q + 4'd1 == WIN_C) state_d = ST_WIN;
            end else if (miss) begin
               if (lives_q <= 4'd1) begin
                  lives_d = '0;
                  state_d = ST_LOSE;
               end else begin
                  lives_d = lives_q - 4'd1;
               end
            end
         end
         default: begin
            // IDLE, WIN and LOSE all react only to start.
            if (start) begin
               score_d = '0;
               lives_d = LIVES_C;
               state_d = ST_PLAY;
            end
         end
      endcase
   end

   // The timer runs only while the FSM stays in WIN or LOSE.
   assign restart = !(((state_q == ST_WIN) || (state_q == ST_LOSE)) && (state_d == state_q));

   blink_timer #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .phase   (phase)
   );

   always_comb begin
      disp_d = {N_DIGITS{SEG_DASH}};
      case (state_q)
         ST_IDLE: begin
            disp_d[5*N_DIGITS-1 -: 5] = SEG_OFF;
            disp_d[4:0]               = SEG_OFF;
         end
         ST_PLAY: begin
            disp_d[5*N_DIGITS-1 -: 5] = {1'b0, score_q};
            disp_d[4:0]               = {1'b0, lives_q};
         end
         ST_WIN: begin
            disp_d[5*N_DIGITS-1 -: 5] = phase ? {1'b0, score_q} : SEG_OFF;
            disp_d[4:0]               = {1'b0, lives_q};
         end
         default: begin
            disp_d[5*N_DIGITS-1 -: 5] = {1'b0, score_q};
            disp_d[4:0]               = phase ? 5'd0 : SEG_OFF;
         end
      endcase
   end

   // Flags track the next state so they move on the transition edge itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         bits_q    <= {SEG_OFF, {(N_DIGITS-2){SEG_DASH}}, SEG_OFF};
         victory_q <= 1'b0;
         lose_q    <= 1'b0;
      end else begin
         bits_q    <= disp_d;
         victory_q <= (state_d == ST_WIN);
         lose_q    <= (state_d == ST_LOSE);
      end
   end

   assign bits        = bits_q;
   assign victoryflag = victory_q;
   assign loseflag    = lose_q;

endmodule

`default_nettype wire

// File: tb/tb_game_progress.sv
// +--------------------------------------------------------------------+
// | tb_game_progress : directed table-driven bench for game_progress   |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_game_progress;

   localparam logic [4:0] D   = 5'd16;
   localparam logic [4:0] OFF = 5'd31;

   logic        clk = 1'b0;
   logic        reset, start, hit, miss;
   logic [19:0] bits;
   logic        victoryflag, loseflag;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       nm;
      logic        s, h, m;
      logic [19:0] b;
      logic        vf, lf;
   } vec_t;

   vec_t vecs[$];

   game_progress #(
      .N_DIGITS  (4),
      .WIN_COUNT (7),
      .LIVES     (3),
      .BLINK_DIV (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .hit         (hit),
      .miss        (miss),
      .bits        (bits),
      .victoryflag (victoryflag),
      .loseflag    (loseflag)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] mk(input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] c, input logic [4:0] d);
      return {a, b, c, d};
   endfunction

   function automatic logic [19:0] bp(input logic [4:0] s, input logic [4:0] l);
      return mk(s, D, D, l);
   endfunction

   task automatic add(input string nm, input logic s, input logic h, input logic m,
                      input logic [19:0] b, input logic vf, input logic lf);
      vec_t v;
      v.nm = nm; v.s = s; v.h = h; v.m = m; v.b = b; v.vf = vf; v.lf = lf;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [19:0] b, input logic vf, input logic lf);
      checks++;
      if (bits !== b || victoryflag !== vf || loseflag !== lf) begin
         failures++;
         $display("FAIL %s: got bits=%05h vf=%b lf=%b, required bits=%05h vf=%b lf=%b",
                  nm, bits, victoryflag, loseflag, b, vf, lf);
      end
   endtask

   // Drive one cycle of inputs between edges, sample just after the rising edge.
   task automatic step(input logic r, input logic s, input logic h, input logic m);
      @(negedge clk);
      reset = r; start = s; hit = h; miss = m;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] idle_p;
      idle_p = mk(OFF, D, D, OFF);

      // Bits at an edge reflect the state held before that edge; flags the state after.
      add("idle_miss",   0, 0, 1, idle_p,     0, 0);
      add("idle_hit",    0, 1, 0, idle_p,     0, 0);
      add("start",       1, 0, 0, idle_p,     0, 0);
      add("play_s0l3",   0, 0, 0, bp(0, 3),   0, 0);
      add("hit1",        0, 1, 0, bp(0, 3),   0, 0);
      add("hit2",        0, 1, 0, bp(1, 3),   0, 0);
      add("miss_l2",     0, 0, 1, bp(2, 3),   0, 0);
      add("hit_and_miss",0, 1, 1, bp(2, 2),   0, 0);
      add("after_hm",    0, 0, 0, bp(3, 2),   0, 0);
      add("start_hit",   1, 1, 0, bp(3, 2),   0, 0);
      add("after_sh",    0, 0, 0, bp(0, 3),   0, 0);
      add("miss_a",      0, 0, 1, bp(0, 3),   0, 0);
      add("miss_b",      0, 0, 1, bp(0, 2),   0, 0);
      add("miss_lose",   0, 0, 1, bp(0, 1),   0, 1);
      add("lose_ph1_a",  0, 0, 0, bp(0, 0),   0, 1);
      add("lose_hit",    0, 1, 0, bp(0, 0),   0, 1);
      add("lose_miss",   0, 0, 1, bp(0, 0),   0, 1);
      add("lose_ph1_d",  0, 0, 0, bp(0, 0),   0, 1);
      add("lose_off_a",  0, 0, 0, bp(0, OFF), 0, 1);
      add("lose_off_b",  0, 0, 0, bp(0, OFF), 0, 1);
      add("lose_off_c",  0, 0, 0, bp(0, OFF), 0, 1);
      add("lose_off_d",  0, 0, 0, bp(0, OFF), 0, 1);
      add("lose_ph1_e",  0, 0, 0, bp(0, 0),   0, 1);
      add("lose_start",  1, 0, 0, bp(0, 0),   0, 0);
      add("replay",      0, 0, 0, bp(0, 3),   0, 0);

      reset = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0;
      step(1, 0, 0, 0);
      step(1, 1, 1, 1);
      check("reset", idle_p, 0, 0);
      step(1, 0, 0, 0);

      foreach (vecs[i]) begin
         step(0, vecs[i].s, vecs[i].h, vecs[i].m);
         check(vecs[i].nm, vecs[i].b, vecs[i].vf, vecs[i].lf);
      end

      // Seven hits to WIN: victoryflag must rise exactly on the seventh edge.
      for (int k = 1; k <= 7; k++) begin
         step(0, 0, 1, 0);
         check($sformatf("win_hit%0d", k), bp(5'(k - 1), 3), (k == 7), 0);
      end

      // Keep hitting while in WIN; digit 0 blinks 7/off every 4 cycles.
      for (int j = 1; j <= 12; j++) begin
         step(0, 0, 1, (j % 3 == 0));
         check($sformatf("win_blink%0d", j),
               bp((((j - 1) / 4) % 2 == 0) ? 5'd7 : OFF, 3), 1, 0);
      end

      step(1, 1, 1, 0);
      check("reset_in_win", idle_p, 0, 0);
      step(0, 0, 0, 1);
      check("idle_after_reset", idle_p, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
